// File: rtl/mem_access_stage.sv
// MIPS MEM stage: branch resolution, multi-cycle data-memory access with upstream
// stall, and the MEM/WB pipeline register feeding write-back.
module mem_access_stage #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  WB_in,
  input  logic [2:0]  M_in,
  input  logic [31:0] ALU_in,
  input  logic        Zero_in,
  input  logic [31:0] ADD_in,
  input  logic [31:0] B_in,
  input  logic [4:0]  MUX_in,
  output logic        PCSrc,
  output logic [31:0] PC_branch,
  output logic        stall,
  output logic [1:0]  WB_out,
  output logic [31:0] Read_data,
  output logic [31:0] ALU_out,
  output logic [4:0]  MUX_out
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        req, commit;
  logic [ADDR_W-1:0] addr;
  logic [31:0] mem [DEPTH];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{ALU_in[31:ADDR_W+2], ALU_in[1:0]};

  assign addr      = ALU_in[ADDR_W+1:2];
  assign req       = M_in[1] | M_in[0];
  assign PCSrc     = M_in[2] & Zero_in;
  assign PC_branch = ADD_in;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req && LATENCY > 0) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall  = 1'b0;
    commit = 1'b0;
    case (state)
      IDLE: begin
        stall  = req && (LATENCY > 0);
        commit = req && (LATENCY == 0);
      end
      BUSY: begin
        stall  = 1'b1;
        commit = (cnt == 4'd0);
      end
      default: ;
    endcase
  end

  // Reset gates the write so an access aborted by reset never lands in memory.
  always_ff @(posedge clk) begin
    if (reset && commit && M_in[0]) mem[addr] <= B_in;
  end

  // Commit edges load like unstalled edges; other stalled edges inject a bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      WB_out    <= '0;
      Read_data <= '0;
      ALU_out   <= '0;
      MUX_out   <= '0;
    end else if (commit || !stall) begin
      WB_out    <= WB_in;
      ALU_out   <= ALU_in;
      MUX_out   <= MUX_in;
      Read_data <= M_in[1] ? mem[addr] : '0;
    end else begin
      WB_out    <= '0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against a word-array memory model.
module tb_mem_access_stage;
  localparam int LAT   = 2;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  WB_in;
  logic [2:0]  M_in;
  logic [31:0] ALU_in, ADD_in, B_in;
  logic        Zero_in;
  logic [4:0]  MUX_in;
  logic        PCSrc, stall;
  logic [31:0] PC_branch, Read_data, ALU_out;
  logic [1:0]  WB_out;
  logic [4:0]  MUX_out;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] ref_mem [DEPTH];

  // Outputs of the last do_op call
  int          o_stall_cycles;
  logic        o_bubble_bad, o_stall_after, o_pcsrc;
  logic [31:0] o_pcb;

  mem_access_stage #(.DEPTH(DEPTH), .ADDR_W(8), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .WB_in(WB_in), .M_in(M_in), .ALU_in(ALU_in),
    .Zero_in(Zero_in), .ADD_in(ADD_in), .B_in(B_in), .MUX_in(MUX_in),
    .PCSrc(PCSrc), .PC_branch(PC_branch), .stall(stall), .WB_out(WB_out),
    .Read_data(Read_data), .ALU_out(ALU_out), .MUX_out(MUX_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  function automatic int waddr(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  // Called just after a rising edge; returns just after the edge that should commit.
  task automatic do_op(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] alu,
                       input logic [31:0] b, input logic [4:0] mux, input logic z,
                       input logic [31:0] add);
    int n;
    logic [31:0] held_alu;
    WB_in = wb; M_in = m; ALU_in = alu; B_in = b; MUX_in = mux; Zero_in = z; ADD_in = add;
    n = (m[1] | m[0]) ? LAT + 1 : 1;
    o_stall_cycles = 0;
    o_bubble_bad = 1'b0;
    held_alu = ALU_out;
    for (int k = 0; k < n; k++) begin
      #3;
      if (k == 0) begin o_pcsrc = PCSrc; o_pcb = PC_branch; end
      if (stall === 1'b1) o_stall_cycles++;
      @(posedge clk); #1;
      if (k < n - 1 && (WB_out !== 2'b00 || ALU_out !== held_alu)) o_bubble_bad = 1'b1;
    end
    WB_in = 2'b00; M_in = 3'b000;
    #1;
    o_stall_after = stall;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    WB_in = 2'b11; M_in = 3'b000; ALU_in = 32'hFFFF_FFFF; B_in = '0; MUX_in = 5'd31;
    Zero_in = 1'b0; ADD_in = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({WB_out, Read_data, ALU_out, MUX_out} !== '0) begin
      n_err++; $display("FAIL reset_regs: got wb=%b rd=%h alu=%h mux=%0d, want all 0",
                        WB_out, Read_data, ALU_out, MUX_out); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
    reset = 1'b1; WB_in = 2'b00;
    #3;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL idle_stall: got %b want 0", stall); end
    @(posedge clk); #1;
  endtask

  task automatic preload;
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] d;
      d = $urandom;
      do_op(2'b00, 3'b001, 32'(i * 4), d, 5'd0, 1'b0, '0);
      ref_mem[i] = d;
    end
  endtask

  task automatic test_store_load;
    do_op(2'b00, 3'b001, 32'h10, 32'hDEAD_BEEF, 5'd0, 1'b0, '0);
    ref_mem[waddr(32'h10)] = 32'hDEAD_BEEF;
    n_cmp++; if (o_stall_cycles != LAT + 1) begin n_err++;
      $display("FAIL store_stall_len: got %0d cycles want %0d", o_stall_cycles, LAT + 1); end
    n_cmp++; if (o_stall_after !== 1'b0) begin n_err++;
      $display("FAIL store_stall_drop: got %b want 0", o_stall_after); end
    n_cmp++; if (o_bubble_bad) begin n_err++; $display("FAIL store_bubble: got bad bubble want WB_out=0"); end
    do_op(2'b11, 3'b010, 32'h10, '0, 5'd9, 1'b0, '0);
    n_cmp++; if (Read_data !== 32'hDEAD_BEEF || WB_out !== 2'b11 || MUX_out !== 5'd9) begin n_err++;
      $display("FAIL load_back: got rd=%h wb=%b mux=%0d want DEADBEEF 11 9", Read_data, WB_out, MUX_out); end
    n_cmp++; if (o_stall_cycles != LAT + 1) begin n_err++;
      $display("FAIL load_stall_len: got %0d want %0d", o_stall_cycles, LAT + 1); end
  endtask

  task automatic test_rtype;
    do_op(2'b10, 3'b000, 32'h1234, 32'h5, 5'd5, 1'b0, '0);
    n_cmp++; if (o_stall_cycles != 0) begin n_err++;
      $display("FAIL rtype_stall: got %0d cycles want 0", o_stall_cycles); end
    n_cmp++; if (WB_out !== 2'b10 || ALU_out !== 32'h1234 || MUX_out !== 5'd5 || Read_data !== '0) begin
      n_err++; $display("FAIL rtype_regs: got wb=%b alu=%h mux=%0d rd=%h want 10 1234 5 0",
                        WB_out, ALU_out, MUX_out, Read_data); end
  endtask

  task automatic test_branch;
    do_op(2'b00, 3'b100, 32'h0, '0, 5'd0, 1'b1, 32'h40);
    n_cmp++; if (o_pcsrc !== 1'b1 || o_pcb !== 32'h40) begin n_err++;
      $display("FAIL branch_taken: got pcsrc=%b pc=%h want 1 40", o_pcsrc, o_pcb); end
    n_cmp++; if (o_stall_cycles != 0) begin n_err++;
      $display("FAIL branch_stall: got %0d want 0", o_stall_cycles); end
    do_op(2'b00, 3'b100, 32'h0, '0, 5'd0, 1'b0, 32'h80);
    n_cmp++; if (o_pcsrc !== 1'b0 || o_pcb !== 32'h80) begin n_err++;
      $display("FAIL branch_not_taken: got pcsrc=%b pc=%h want 0 80", o_pcsrc, o_pcb); end
  endtask

  task automatic test_wrap;
    do_op(2'b00, 3'b001, 32'h400, 32'h55, 5'd0, 1'b0, '0);
    ref_mem[waddr(32'h400)] = 32'h55;
    do_op(2'b10, 3'b010, 32'h0, '0, 5'd1, 1'b0, '0);
    n_cmp++; if (Read_data !== 32'h55) begin n_err++;
      $display("FAIL wrap_addr: got %h want 00000055", Read_data); end
    do_op(2'b00, 3'b001, 32'h13, 32'h0BAD_F00D, 5'd0, 1'b0, '0);
    ref_mem[waddr(32'h13)] = 32'h0BAD_F00D;
    do_op(2'b10, 3'b010, 32'h10, '0, 5'd1, 1'b0, '0);
    n_cmp++; if (Read_data !== 32'h0BAD_F00D) begin n_err++;
      $display("FAIL low_bits_ignored: got %h want 0badf00d", Read_data); end
  endtask

  task automatic test_read_write_same;
    logic [31:0] old;
    old = ref_mem[waddr(32'h80)];
    do_op(2'b11, 3'b011, 32'h80, 32'h7777_1111, 5'd3, 1'b0, '0);
    ref_mem[waddr(32'h80)] = 32'h7777_1111;
    n_cmp++; if (Read_data !== old) begin n_err++;
      $display("FAIL rw_old_data: got %h want %h", Read_data, old); end
    do_op(2'b11, 3'b010, 32'h80, '0, 5'd3, 1'b0, '0);
    n_cmp++; if (Read_data !== 32'h7777_1111) begin n_err++;
      $display("FAIL rw_new_data: got %h want 77771111", Read_data); end
  endtask

  task automatic test_reset_mid_access;
    do_op(2'b00, 3'b001, 32'h20, 32'h1111_2222, 5'd0, 1'b0, '0);
    ref_mem[waddr(32'h20)] = 32'h1111_2222;
    WB_in = 2'b00; M_in = 3'b001; ALU_in = 32'h20; B_in = 32'hAA;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; M_in = 3'b000;
    #1;
    n_cmp++; if (stall !== 1'b0 || WB_out !== 2'b00 || ALU_out !== '0) begin n_err++;
      $display("FAIL abort_state: got stall=%b wb=%b alu=%h want 0 0 0", stall, WB_out, ALU_out); end
    #2;
    @(posedge clk); #1;
    do_op(2'b10, 3'b010, 32'h20, '0, 5'd2, 1'b0, '0);
    n_cmp++; if (Read_data !== 32'h1111_2222) begin n_err++;
      $display("FAIL abort_no_write: got %h want 11112222", Read_data); end
    n_cmp++; if (o_stall_cycles != LAT + 1) begin n_err++;
      $display("FAIL abort_fresh_count: got %0d want %0d", o_stall_cycles, LAT + 1); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 80; i++) begin
      logic [2:0]  m;
      logic [1:0]  wb;
      logic [31:0] alu, b, add;
      logic [4:0]  mux;
      logic        z;
      logic [31:0] exp_rd;
      int          exp_st;
      case ($urandom_range(0, 4))
        0: m = 3'b000;
        1: m = 3'b100;
        2: m = 3'b010;
        3: m = 3'b001;
        default: m = 3'b011;
      endcase
      wb = 2'($urandom); alu = $urandom; b = $urandom; add = $urandom;
      mux = 5'($urandom); z = 1'($urandom);
      exp_rd = m[1] ? ref_mem[waddr(alu)] : 32'h0;
      exp_st = (m[1] | m[0]) ? LAT + 1 : 0;
      if (m[0]) ref_mem[waddr(alu)] = b;
      do_op(wb, m, alu, b, mux, z, add);
      n_cmp++; if (WB_out !== wb || ALU_out !== alu || MUX_out !== mux || Read_data !== exp_rd) begin
        n_err++; $display("FAIL rand_regs[%0d]: got wb=%b alu=%h mux=%0d rd=%h want %b %h %0d %h",
                          i, WB_out, ALU_out, MUX_out, Read_data, wb, alu, mux, exp_rd); end
      n_cmp++; if (o_stall_cycles != exp_st || o_stall_after !== 1'b0 || o_bubble_bad) begin
        n_err++; $display("FAIL rand_stall[%0d]: got %0d cycles after=%b bubble_bad=%b want %0d 0 0",
                          i, o_stall_cycles, o_stall_after, o_bubble_bad, exp_st); end
      n_cmp++; if (o_pcsrc !== (m[2] & z) || o_pcb !== add) begin
        n_err++; $display("FAIL rand_branch[%0d]: got %b %h want %b %h", i, o_pcsrc, o_pcb, m[2] & z, add); end
    end
  endtask

  initial begin
    test_reset;
    preload;
    test_store_load;
    test_rtype;
    test_branch;
    test_wrap;
    test_read_write_same;
    test_reset_mid_access;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
